sd_block_arbiter: RTL and testbench
===================================

Name: sd_block_arbiter

Overview:
Two-requester arbiter for the SD card block-read interface. It lets the FAT32 reader (port 0) and a second client (port 1, e.g. directory/playlist browser) share the single SDCard_reader. Ownership is granted at whole-session granularity: a session may contain any number of single or continuous block reads. The block sits between the requesters and SDCard_reader, muxing the command side and gating the data-side strobes.

Parameters:
SD_BLOCK_ADDR_BITS, 32, width of block address
SD_BLOCK_LENGHT_BITS, 9, width of byte index within a 512-byte block
STARVE_CYCLES, 2**24, wait cycles after which a pending requester raises its starve flag

Ports:
clk  in  1  system clock (200 MHz domain)
rst_n  in  1  asynchronous active-low reset
card_configured_i  in  1  SD card initialised
req_i  in  2  per-requester session request, level
gnt_o  out  2  per-requester grant, one-hot or zero, registered
trig_i  in  2  per-requester block-read trigger pulse
cont_i  in  2  per-requester continuous-mode level
addr0_i  in  SD_BLOCK_ADDR_BITS  requester 0 block address
addr1_i  in  SD_BLOCK_ADDR_BITS  requester 1 block address
ready_o  out  2  per-requester card_ready (card ready AND granted)
new_flag_o  out  2  per-requester data-new strobe (card strobe AND granted)
data_o  out  8  read byte, broadcast
idx_o  out  SD_BLOCK_LENGHT_BITS  byte index, broadcast
starve_o  out  2  sticky per-requester starvation flag
card_trig_o  out  1  to SDCard_reader block_read_trigger
card_cont_o  out  1  to SDCard_reader block_read_continous_mode
card_addr_o  out  SD_BLOCK_ADDR_BITS  to SDCard_reader block_read_block_addr
card_ready_i  in  1  from SDCard_reader block_read_card_ready
card_data_i  in  8  from SDCard_reader data_out
card_idx_i  in  SD_BLOCK_LENGHT_BITS  from SDCard_reader data_idx
card_new_i  in  1  from SDCard_reader data_new_flag

Behaviour:
- Reset (async, rst_n low): state IDLE; gnt_o=0; starve_o=0; last-granted pointer=1 (so port 0 wins the first tie); wait counters=0. Combinational outputs follow, so card_trig_o=0, card_cont_o=0, card_addr_o=0, ready_o=0, new_flag_o=0.
- States: IDLE, OWN, DRAIN, GAP. The granted index is held in a register alongside the state.
- IDLE -> OWN: requires card_configured_i=1, card_ready_i=1 and at least one req_i bit set. A single request wins. If both are set, the winner is the port not last granted (round-robin). gnt_o asserts on the clock edge after req_i is sampled (1-cycle grant latency).
- OWN:
  - card_trig_o, card_cont_o and card_addr_o are combinational copies of the granted port's inputs.
  - Non-granted trig/cont/addr are ignored.
  - ready_o[g]=card_ready_i; new_flag_o[g]=card_new_i; the non-granted bits are 0.
- Leaving OWN when req_i[g] drops:
  - card_ready_i=1: -> GAP.
  - card_ready_i=0 (transfer in flight): -> DRAIN.
- DRAIN: gnt_o held; card_cont_o forced 0 so the current block ends; card_trig_o forced 0; new_flag_o[g] still passed. Exit to GAP when card_ready_i=1.
- GAP: exactly one cycle. gnt_o=0, all card command outputs 0, last-granted pointer updated. Then -> IDLE. The minimum turnaround between sessions is therefore 2 cycles after release.
- card_configured_i falling in any state: -> IDLE on the next edge; gnt_o cleared, command outputs 0. The abort is not reported to the requester beyond grant loss.
- A trigger issued in the same cycle as req_i[g] drops is not forwarded.
- Starvation:
  - A per-port counter increments each cycle the port has req_i=1 and gnt_o=0; it saturates at STARVE_CYCLES.
  - The counter clears when the port is granted or drops req_i.
  - starve_o bit sets when the counter reaches STARVE_CYCLES and stays set until reset.
- data_o and idx_o are always card_data_i and card_idx_i, unregistered.
- gnt_o is never two-hot. It is never asserted while card_configured_i=0.

Test Plan:
- Reset then req_i=2'b11 with card ready/configured -> gnt_o=2'b01 one cycle later. Drop req0 -> 1-cycle GAP, gnt_o=2'b10 two cycles after release.
- Port 1 owns the card and pulses trig_i[1] with addr1_i=0x0000_1234 -> card_trig_o pulses with card_addr_o=0x0000_1234. trig_i[0] in the same cycle is ignored. 512 card_new_i strobes appear only on new_flag_o[1].
- Port 0 in continuous mode drops req_i[0] with card_ready_i=0 -> card_cont_o=0 and gnt_o=2'b01 held until card_ready_i=1, then one cycle of gnt_o=0.
- card_configured_i deasserted mid-transfer -> gnt_o=0 and card_trig_o=card_cont_o=0 on the next edge. No grant while it stays low, even with req_i=2'b11.
- STARVE_CYCLES=16, port 0 holds its session for 20 cycles while req_i[1]=1 -> starve_o=2'b10 from the 16th wait cycle. It stays set after port 1 is granted, until rst_n low.
- rst_n pulsed low mid-session -> all outputs 0 immediately (async). After release, req_i=2'b11 grants port 0 first.

Source files
------------

// File: rtl/sd_block_arbiter.sv
// Two-requester session arbiter in front of SDCard_reader: round-robin grant per session,
// command-side mux, data-strobe gating and sticky starvation flags.
module sd_block_arbiter #(
    parameter int unsigned SD_BLOCK_ADDR_BITS   = 32,
    parameter int unsigned SD_BLOCK_LENGHT_BITS = 9,
    parameter int unsigned STARVE_CYCLES        = 2**24
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            card_configured_i,
    input  logic [1:0]                      req_i,
    output logic [1:0]                      gnt_o,
    input  logic [1:0]                      trig_i,
    input  logic [1:0]                      cont_i,
    input  logic [SD_BLOCK_ADDR_BITS-1:0]   addr0_i,
    input  logic [SD_BLOCK_ADDR_BITS-1:0]   addr1_i,
    output logic [1:0]                      ready_o,
    output logic [1:0]                      new_flag_o,
    output logic [7:0]                      data_o,
    output logic [SD_BLOCK_LENGHT_BITS-1:0] idx_o,
    output logic [1:0]                      starve_o,
    output logic                            card_trig_o,
    output logic                            card_cont_o,
    output logic [SD_BLOCK_ADDR_BITS-1:0]   card_addr_o,
    input  logic                            card_ready_i,
    input  logic [7:0]                      card_data_i,
    input  logic [SD_BLOCK_LENGHT_BITS-1:0] card_idx_i,
    input  logic                            card_new_i
);

    localparam int unsigned CntW = $clog2(STARVE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(STARVE_CYCLES);
    localparam logic [CntW-1:0] CntPrev = CntW'(STARVE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StOwn, StDrain, StGap} state_e;

    state_e     state_q;
    logic [1:0] gnt_q;
    logic       gnt_idx_q;
    logic       last_q;

    logic live;
    logic own_req;
    logic winner;

    assign live    = card_configured_i && (state_q == StOwn || state_q == StDrain);
    assign own_req = req_i[gnt_idx_q];
    // On a tie the port not served last wins; otherwise the lone requester.
    assign winner  = (&req_i) ? ~last_q : req_i[1];

    // Grant loss is immediate when the card drops out, not one edge late.
    assign gnt_o  = gnt_q & {2{card_configured_i}};
    assign data_o = card_data_i;
    assign idx_o  = card_idx_i;

    always_comb begin
        card_trig_o = 1'b0;
        card_cont_o = 1'b0;
        card_addr_o = '0;
        ready_o     = '0;
        new_flag_o  = '0;
        if (live) begin
            card_addr_o           = gnt_idx_q ? addr1_i : addr0_i;
            new_flag_o[gnt_idx_q] = card_new_i;
            if (state_q == StOwn) begin
                ready_o[gnt_idx_q] = card_ready_i;
                // A release in this cycle suppresses both trigger and continuous mode.
                card_trig_o        = own_req & trig_i[gnt_idx_q];
                card_cont_o        = own_req & cont_i[gnt_idx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_idx_q <= 1'b0;
            last_q    <= 1'b1;
        end else if (!card_configured_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (card_ready_i && (|req_i)) begin
                        state_q   <= StOwn;
                        gnt_idx_q <= winner;
                        gnt_q     <= winner ? 2'b10 : 2'b01;
                    end
                end
                StOwn: begin
                    if (!own_req) begin
                        if (card_ready_i) begin
                            state_q <= StGap;
                            gnt_q   <= '0;
                            last_q  <= gnt_idx_q;
                        end else begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (card_ready_i) begin
                        state_q <= StGap;
                        gnt_q   <= '0;
                        last_q  <= gnt_idx_q;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_starve
        logic [CntW-1:0] wait_q;
        logic            starve_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wait_q   <= '0;
                starve_q <= 1'b0;
            end else if (req_i[p] && !gnt_o[p]) begin
                if (wait_q != CntMax) begin
                    wait_q <= wait_q + 1'b1;
                end
                if (wait_q >= CntPrev) begin
                    starve_q <= 1'b1;
                end
            end else begin
                wait_q <= '0;
            end
        end

        assign starve_o[p] = starve_q;
    end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Bench for sd_block_arbiter: directed session scenarios followed by random traffic,
// every cycle compared against a session-level reference model.
module tb_sd_block_arbiter;

    localparam int unsigned N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg = 1'b1;
    logic [1:0]  req = '0, trig = '0, cont = '0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic        card_ready = 1'b1, card_new = 1'b0;
    logic [7:0]  card_data = '0;
    logic [8:0]  card_idx = '0;

    logic [1:0]  gnt_o, ready_o, new_flag_o, starve_o;
    logic [7:0]  data_o;
    logic [8:0]  idx_o;
    logic        card_trig_o, card_cont_o;
    logic [31:0] card_addr_o;

    int checks = 0;
    int fails  = 0;

    // Reference model: who owns the card, whether it is winding down, the one-cycle gap.
    int       m_owner;
    bit       m_drain, m_gap;
    int       m_last;
    int       m_wait [2];
    bit [1:0] m_starve;

    sd_block_arbiter #(
        .SD_BLOCK_ADDR_BITS  (32),
        .SD_BLOCK_LENGHT_BITS(9),
        .STARVE_CYCLES       (N)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .card_configured_i(cfg),
        .req_i            (req),
        .gnt_o            (gnt_o),
        .trig_i           (trig),
        .cont_i           (cont),
        .addr0_i          (addr0),
        .addr1_i          (addr1),
        .ready_o          (ready_o),
        .new_flag_o       (new_flag_o),
        .data_o           (data_o),
        .idx_o            (idx_o),
        .starve_o         (starve_o),
        .card_trig_o      (card_trig_o),
        .card_cont_o      (card_cont_o),
        .card_addr_o      (card_addr_o),
        .card_ready_i     (card_ready),
        .card_data_i      (card_data),
        .card_idx_i       (card_idx),
        .card_new_i       (card_new)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_drain  = 1'b0;
        m_gap    = 1'b0;
        m_last   = 1;
        m_wait   = '{0, 0};
        m_starve = '0;
    endtask

    task automatic model_edge(input logic [1:0] g);
        for (int p = 0; p < 2; p++) begin
            if (req[p] && !g[p]) begin
                if (m_wait[p] < N) m_wait[p]++;
                if (m_wait[p] == N) m_starve[p] = 1'b1;
            end else begin
                m_wait[p] = 0;
            end
        end
        if (!cfg) begin
            m_owner = -1;
            m_drain = 1'b0;
            m_gap   = 1'b0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            if (card_ready && req != 2'b00)
                m_owner = (req == 2'b11) ? 1 - m_last : (req[0] ? 0 : 1);
        end else if (m_drain || !req[m_owner]) begin
            if (card_ready) begin
                m_last  = m_owner;
                m_owner = -1;
                m_drain = 1'b0;
                m_gap   = 1'b1;
            end else begin
                m_drain = 1'b1;
            end
        end
    endtask

    // Check all outputs against the model for the current inputs, then advance one clock.
    task automatic tick(input int n = 1);
        logic [1:0]  eg, er, en;
        logic        et, ec;
        logic [31:0] ea;
        for (int i = 0; i < n; i++) begin
            #1;
            eg = '0; er = '0; en = '0; et = 1'b0; ec = 1'b0; ea = '0;
            if (cfg && m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                ea          = (m_owner == 1) ? addr1 : addr0;
                en[m_owner] = card_new;
                if (!m_drain) begin
                    er[m_owner] = card_ready;
                    if (req[m_owner]) begin
                        et = trig[m_owner];
                        ec = cont[m_owner];
                    end
                end
            end
            chk("gnt", 32'(gnt_o), 32'(eg));
            chk("ready", 32'(ready_o), 32'(er));
            chk("new_flag", 32'(new_flag_o), 32'(en));
            chk("card_trig", 32'(card_trig_o), 32'(et));
            chk("card_cont", 32'(card_cont_o), 32'(ec));
            chk("card_addr", card_addr_o, ea);
            chk("starve", 32'(starve_o), 32'(m_starve));
            chk("data", 32'(data_o), 32'(card_data));
            chk("idx", 32'(idx_o), 32'(card_idx));
            @(posedge clk);
            model_edge(eg);
            #1;
        end
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_trig", 32'(card_trig_o), 32'h0);
        chk("rst_cont", 32'(card_cont_o), 32'h0);
        chk("rst_addr", card_addr_o, 32'h0);
        chk("rst_ready", 32'(ready_o), 32'h0);
        chk("rst_new", 32'(new_flag_o), 32'h0);
        chk("rst_starve", 32'(starve_o), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        async_reset();

        // Tie after reset goes to port 0; release gives port 1 after gap + idle.
        req = 2'b11;
        tick();
        chk("first_grant", 32'(gnt_o), 32'h1);
        tick(2);
        req = 2'b10;
        tick();
        chk("gap_gnt", 32'(gnt_o), 32'h0);
        tick(2);
        chk("second_grant", 32'(gnt_o), 32'h2);

        // Port 1 triggers a read; port 0's simultaneous trigger and address are ignored.
        addr0 = 32'hFFFF_FFFF;
        addr1 = 32'h0000_1234;
        trig  = 2'b11;
        tick();
        trig       = 2'b00;
        card_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            card_new  = 1'b1;
            card_idx  = 9'(i);
            card_data = 8'($urandom);
            tick();
            card_new = 1'b0;
            tick();
        end
        card_ready = 1'b1;
        tick();

        // Port 0 in continuous mode releases mid-block: drain until the card is ready.
        req = 2'b01;
        tick(4);
        cont = 2'b01;
        trig = 2'b01;
        tick();
        trig       = 2'b00;
        card_ready = 1'b0;
        tick(2);
        req = 2'b00;
        tick(5);
        chk("drain_gnt", 32'(gnt_o), 32'h1);
        card_ready = 1'b1;
        tick();
        chk("drain_gap", 32'(gnt_o), 32'h0);
        tick(2);
        cont = 2'b00;

        // Port 0 holds its session while port 1 waits past the starvation threshold.
        req = 2'b01;
        tick(3);
        req = 2'b11;
        tick(20);
        chk("starve_set", 32'(starve_o), 32'h2);
        req = 2'b10;
        tick(5);
        chk("starve_sticky", 32'(starve_o), 32'h2);
        chk("starve_owner", 32'(gnt_o), 32'h2);

        // Async reset in the middle of a session.
        trig = 2'b10;
        cont = 2'b10;
        #3;
        async_reset();
        trig = 2'b00;
        cont = 2'b00;
        req  = 2'b11;
        tick();
        chk("post_rst_grant", 32'(gnt_o), 32'h1);

        // Card deconfigured mid-transfer: no grant while it stays low.
        req = 2'b01;
        tick(2);
        cont       = 2'b01;
        card_ready = 1'b0;
        tick(2);
        cfg = 1'b0;
        req = 2'b11;
        tick(10);
        chk("unconf_gnt", 32'(gnt_o), 32'h0);
        chk("unconf_cont", 32'(card_cont_o), 32'h0);
        cfg        = 1'b1;
        card_ready = 1'b1;
        req        = 2'b00;
        cont       = 2'b00;
        tick(3);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) req = 2'($urandom);
            trig       = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
            cont       = 2'($urandom);
            addr0      = $urandom;
            addr1      = $urandom;
            card_ready = ($urandom_range(3) != 0);
            card_new   = 1'($urandom);
            card_data  = 8'($urandom);
            card_idx   = 9'($urandom);
            if ($urandom_range(63) == 0) cfg = ~cfg;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
